// File: rtl/piso_serializer_if.sv
// piso_serializer_if
// Bundles the word-load handshake, the bit-rate enable and the serial-side
// outputs of the PISO serializer.
//   master : producer/consumer side (drives tick, load_valid, load_data)
//   slave  : serializer side (drives load_ready, ser_out, ser_valid,
//            frame_start, busy)
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic             tick;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output tick, load_valid, load_data,
    input  load_ready, ser_out, ser_valid, frame_start, busy
  );

  modport slave (
    input  tick, load_valid, load_data,
    output load_ready, ser_out, ser_valid, frame_start, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer
// Parallel-in, serial-out shifter with a one-entry holding buffer. A word is
// accepted on load_valid && load_ready and is shifted out one bit per tick.
// A buffered word starts on the tick that retires the last bit of the
// current frame, so back-to-back frames leave no gap bit.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : piso_serializer_if.slave (tick, load handshake, serial outputs)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no frame on the line; waits for a tick with the buffer full
// SHIFT | a frame is being presented; cnt_q = bits still to present
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  piso_serializer_if.slave  bus
);

  localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_start_q, frame_start_d;

  logic             start_frame;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_shifted;

  // ser_out always mirrors the head of shreg_q; shifting moves the next
  // bit into the head position while ser_out takes it on the same edge.
  generate
    if (MSB_FIRST) begin : g_msb
      assign first_bit     = buf_q[WIDTH-1];
      assign next_bit      = shreg_q[WIDTH-2];
      assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign first_bit     = buf_q[0];
      assign next_bit      = shreg_q[1];
      assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    buf_d         = buf_q;
    buf_full_d    = buf_full_q;
    cnt_d         = cnt_q;
    ser_out_d     = ser_out_q;
    ser_valid_d   = ser_valid_q;
    frame_start_d = frame_start_q;
    start_frame   = 1'b0;

    if (bus.tick) begin
      unique case (state_q)
        IDLE: begin
          if (buf_full_q) start_frame = 1'b1;
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            shreg_d       = shreg_shifted;
            ser_out_d     = next_bit;
            cnt_d         = cnt_q - CW'(1);
            frame_start_d = 1'b0;
          end else if (buf_full_q) begin
            start_frame = 1'b1;
          end else begin
            // ser_out deliberately keeps the last bit
            ser_valid_d   = 1'b0;
            frame_start_d = 1'b0;
            state_d       = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (start_frame) begin
      shreg_d       = buf_q;
      buf_full_d    = 1'b0;
      ser_out_d     = first_bit;
      ser_valid_d   = 1'b1;
      frame_start_d = 1'b1;
      cnt_d         = CNT_LAST;
      state_d       = SHIFT;
    end

    // Accept only into an empty buffer; start_frame needs a full one, so
    // the two never collide and a new word cannot start on its accept edge.
    if (bus.load_valid && !buf_full_q) begin
      buf_d      = bus.load_data;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
      cnt_q         <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
      cnt_q         <= cnt_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.load_ready  = !buf_full_q;
  assign bus.ser_out     = ser_out_q;
  assign bus.ser_valid   = ser_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = (state_q == SHIFT) || buf_full_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer
// Drives two serializer instances (MSB-first and LSB-first) through a shared
// stimulus path; sel picks which one is loaded and observed. Expected bits
// are queued on each accept and popped on every tick edge carrying a bit.
module tb_piso_serializer;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       lv;
  logic [7:0] ld;
  logic       sel;

  piso_serializer_if #(.WIDTH(8)) bus0 ();
  piso_serializer_if #(.WIDTH(8)) bus1 ();

  assign bus0.tick       = tick;
  assign bus0.load_valid = lv && !sel;
  assign bus0.load_data  = ld;
  assign bus1.tick       = tick;
  assign bus1.load_valid = lv && sel;
  assign bus1.load_data  = ld;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  logic m_out, m_valid, m_fs, m_busy, m_ready;
  assign m_out   = sel ? bus1.ser_out     : bus0.ser_out;
  assign m_valid = sel ? bus1.ser_valid   : bus0.ser_valid;
  assign m_fs    = sel ? bus1.frame_start : bus0.frame_start;
  assign m_busy  = sel ? bus1.busy        : bus0.busy;
  assign m_ready = sel ? bus1.load_ready  : bus0.load_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] exp_q[$];   // {ser_out, frame_start}
  logic [2:0] prev;       // {ser_out, ser_valid, frame_start} at last sample
  int         tick_div   = 1;
  int         tick_phase = 0;
  int         cyc        = 0;
  int         valid_cnt  = 0;
  int         first_v    = -1;
  int         last_v     = -1;
  int         pops       = 0;

  task automatic clear_stats();
    valid_cnt = 0;
    first_v   = -1;
    last_v    = -1;
    pops      = 0;
  endtask

  task automatic set_pace(input int div);
    tick_div   = div;
    tick_phase = 1 % div;
    tick       = 1'b1;
  endtask

  task automatic push_word(input logic [7:0] d);
    if (!sel) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back({d[i], (i == 7) ? 1'b1 : 1'b0});
    end else begin
      for (int i = 0; i < 8; i++) exp_q.push_back({d[i], (i == 0) ? 1'b1 : 1'b0});
    end
  endtask

  // One clock: inputs already applied; samples at the following negedge.
  task automatic cycle_check();
    logic       tw;
    logic [1:0] e;
    tw = tick;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (m_valid) begin
      valid_cnt++;
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
    if (tw) begin
      if (m_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_bit: ser_valid=1 ser_out=%0b with no bit expected", m_out);
        end else begin
          e = exp_q.pop_front();
          pops++;
          if ({m_out, m_fs} !== e) begin
            n_fail++;
            $display("FAIL serial_bit #%0d: got out=%0b fs=%0b, want out=%0b fs=%0b",
                     pops, m_out, m_fs, e[1], e[0]);
          end
        end
      end
    end else begin
      n_checks++;
      if ({m_out, m_valid, m_fs} !== prev) begin
        n_fail++;
        $display("FAIL hold_between_ticks: got %03b, want %03b", {m_out, m_valid, m_fs}, prev);
      end
    end
    prev = {m_out, m_valid, m_fs};
    tick = (tick_phase == 0);
    tick_phase = (tick_phase + 1) % tick_div;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle_check();
  endtask

  task automatic do_load(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    lv = 1'b1;
    ld = d;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (m_ready) begin
        push_word(d);
        ok = 1'b1;
      end
      cycle_check();
    end
    lv = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL load_timeout: load_ready stayed %0b for 100 cycles, want 1", m_ready);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    n_checks++;
    if ({m_valid, m_out, m_fs, m_busy, m_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL %s: got valid,out,fs,busy,ready=%05b, want 00001", tag,
               {m_valid, m_out, m_fs, m_busy, m_ready});
    end
  endtask

  task automatic check_queue_empty(input string tag);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected bits never emitted, want 0", tag, exp_q.size());
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic test_reset();
    #2;
    sel = 1'b0;
    check_idle_outputs("reset_por_msb");
    sel = 1'b1;
    #1;
    check_idle_outputs("reset_por_lsb");
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    prev  = 3'b000;
  endtask

  task automatic test_single();
    set_pace(1);
    clear_stats();
    do_load(8'hA5);
    drain(12);
    check_queue_empty("single_all_bits");
    check_int("single_valid_cycles", valid_cnt, 8);
    n_checks++;
    if ({m_valid, m_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_after_frame: got valid,busy=%02b, want 00", {m_valid, m_busy});
    end
  endtask

  task automatic test_back_to_back();
    set_pace(1);
    clear_stats();
    do_load(8'h3C);
    do_load(8'hC3);
    drain(20);
    check_queue_empty("b2b_all_bits");
    check_int("b2b_valid_cycles", valid_cnt, 16);
    check_int("b2b_contiguous_span", last_v - first_v + 1, 16);
  endtask

  task automatic test_paced();
    set_pace(4);
    clear_stats();
    do_load(8'h81);
    drain(50);
    check_queue_empty("paced_all_bits");
    check_int("paced_valid_cycles", valid_cnt, 32);
    set_pace(1);
  endtask

  task automatic test_lsb_first();
    set_pace(1);
    sel = 1'b1;
    prev = {m_out, m_valid, m_fs};
    clear_stats();
    do_load(8'h01);
    drain(12);
    check_queue_empty("lsb_all_bits");
    check_int("lsb_valid_cycles", valid_cnt, 8);
    sel = 1'b0;
    prev = {m_out, m_valid, m_fs};
  endtask

  task automatic test_full_buffer();
    set_pace(1);
    clear_stats();
    do_load(8'hFF);
    do_load(8'h0F);
    lv = 1'b1;
    ld = 8'hAA;
    n_checks++;
    if (m_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_load_ready: got %0b, want 0", m_ready);
    end
    cycle_check();
    lv = 1'b0;
    drain(25);
    check_queue_empty("full_all_bits");
    check_int("full_valid_cycles", valid_cnt, 16);
  endtask

  task automatic test_mid_reset();
    set_pace(1);
    clear_stats();
    do_load(8'hFF);
    do_load(8'h0F);
    for (int i = 0; i < 50 && pops < 3; i++) cycle_check();
    check_int("midrst_reached_bit3", pops, 3);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst_async");
    exp_q.delete();
    prev = 3'b000;
    #1;
    rst_n = 1'b1;
    clear_stats();
    drain(20);
    check_int("midrst_no_bits_after", valid_cnt, 0);
    clear_stats();
    do_load(8'h5A);
    drain(12);
    check_queue_empty("midrst_recover_bits");
    check_int("midrst_recover_valid", valid_cnt, 8);
  endtask

  initial begin
    rst_n = 1'b0;
    tick  = 1'b1;
    lv    = 1'b0;
    ld    = 8'h00;
    sel   = 1'b0;
    prev  = 3'b000;
    test_reset();
    test_single();
    test_back_to_back();
    test_paced();
    test_lsb_first();
    test_full_buffer();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
